key_scan: RTL and testbench
===========================

# key_scan

Scanned-matrix keypad reader for the 4x4 keypad header on the board. It is the input-side counterpart of the row-scanned LED matrix driver. It drives one keypad row low at a time, samples the column lines, and assembles a 16-bit frame. Frames are debounced and each new key press is delivered as a 4-bit code through a one-entry valid/ack buffer to the game/control logic.

## Interface
- SCAN_DIV, 1000: clk cycles each row is driven before sampling (≥2); 1 kHz row rate at 1 MHz clk.
- DEBOUNCE, 3: consecutive identical frames (after the first) needed to accept a frame (1..15).

- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous reset, active low.
- col_i  input  4  column sense lines, pulled up externally; low = key closed on the driven row.
- row_o  output  4  row drive, one-hot active low.
- key_code  output  4  index of the pressed key, row*4+col.
- key_valid  output  1  key_code holds an unacknowledged press.
- key_ack  input  1  consumer accepts key_code; ignored when key_valid=0.
- overrun  output  1  sticky; a press was lost while the buffer was full.
- key_down  output  1  at least one key is down in the debounced map.
- pressed_map  output  16  debounced map; bit row*4+col = 1 means pressed.

## Operation
- Divider: div counts 0..SCAN_DIV-1 and wraps. tick = (div == SCAN_DIV-1).
- Row index r (2 bits): row_o = ~(4'b0001 << r).
- On each tick, in a single edge:
  - frame bits [r*4+3 : r*4] ← ~col_i.
  - r ← r+1; r wraps 3→0.
- Frame end: the tick with r==3. At that edge:
  - prev_frame ← assembled frame.
  - stable_cnt ← 0 if frame ≠ prev_frame, else min(stable_cnt+1, DEBOUNCE).
- Accept, one cycle after frame end: if stable_cnt==DEBOUNCE and prev_frame ≠ pressed_map, then pressed_map ← prev_frame and new = prev_frame & ~old pressed_map.
- Release only clears pressed_map bits. It generates no event.
- Encoding: if new ≠ 0, code = lowest set index. Other simultaneously new keys are dropped silently; this is not an overrun.
- Buffer, evaluated on the cycle after accept:
  - Press and key_valid=0: key_code ← code, key_valid ← 1.
  - Press, key_valid=1, key_ack=1: key_code ← code, key_valid stays 1.
  - Press, key_valid=1, key_ack=0: key_code unchanged, overrun ← 1.
  - No press, key_ack=1: key_valid ← 0; key_code holds its last value.
- overrun clears only on a key_ack cycle that does not itself overrun, or on reset.
- key_down = |pressed_map (registered with pressed_map).

## Timing
- Reset (rst_n low at an edge) sets:
  - div=0, r=0, row_o=4'b1110
  - frame, prev_frame, stable_cnt, pressed_map = 0
  - key_code=0, key_valid=0, overrun=0, key_down=0
- Reset mid-scan or mid-debounce discards all partial state. No key event is generated from pre-reset data.
- The first tick after reset occurs SCAN_DIV cycles after rst_n is released. Each row is driven for exactly SCAN_DIV cycles.
- Frame period: 4*SCAN_DIV cycles.
- Press latency:
  - A press stable from before frame F0 (F0 differs from its predecessor) is accepted at end of frame F_DEBOUNCE + 1 cycle.
  - key_valid rises the following cycle, i.e. frame-end edge + 2 cycles.
- A bounce inside any row sample resets stable_cnt. Acceptance then needs DEBOUNCE further identical frames.
- key_ack and a new press on the same edge: no gap in key_valid, no overrun.
- A held key produces exactly one event. Re-press requires a debounced release first.

## Test plan
- Reset/scan: rst_n low 3 cycles, SCAN_DIV=4 → row_o = 1110, 1101, 1011, 0111, 1110 changing every 4 cycles; all other outputs 0.
- Single press: SCAN_DIV=4, DEBOUNCE=2, col_i[2] low only while row 1 is driven, held indefinitely →
  - key_code=6 and key_valid=1 two cycles after the 3rd frame-end tick.
  - pressed_map=16'h0040, key_down=1.
  - Exactly one event.
- Bounce: same press toggled off for one frame mid-debounce → key_valid is delayed by 3 further frame periods; still exactly one event, code 6.
- Simultaneous keys: keys 9 and 3 pressed together → key_code=3, pressed_map=16'h0208, no overrun. Releasing key 3 and keeping key 9 → no new event.
- Overrun/ack: press key 0, no ack, release, press key 5 → overrun=1, key_code stays 0. Pulse key_ack → key_valid=0, overrun=0.
- Ack collision: key_ack asserted on the exact cycle a new press (key 15) loads → key_valid stays 1, key_code=15, overrun=0.

Source files
------------

// File: rtl/key_scan.sv
// rtl/key_scan.sv - 4x4 scanned keypad reader with frame debounce and one-entry key buffer
module key_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_i,
  output logic [3:0]  row_o,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        overrun,
  output logic        key_down,
  output logic [15:0] pressed_map
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic [1:0]       r;
  logic [15:0]      frame;
  logic [15:0]      prev_frame;
  logic [3:0]       stable_cnt;
  logic             frame_end_d;
  logic             press_pend;
  logic [3:0]       pend_code;

  logic             tick;
  logic [15:0]      full_frame;
  logic [15:0]      new_bits;
  logic [3:0]       lowest;

  assign tick       = (div == DIV_W'(SCAN_DIV - 1));
  assign row_o      = ~(4'b0001 << r);
  // The last row is still being sampled on the frame-end edge, so splice it in directly.
  assign full_frame = {~col_i, frame[11:0]};
  assign new_bits   = prev_frame & ~pressed_map;

  always_comb begin
    lowest = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (new_bits[i]) lowest = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div         <= '0;
      r           <= 2'd0;
      frame       <= 16'd0;
      prev_frame  <= 16'd0;
      stable_cnt  <= 4'd0;
      frame_end_d <= 1'b0;
      press_pend  <= 1'b0;
      pend_code   <= 4'd0;
      pressed_map <= 16'd0;
      key_down    <= 1'b0;
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      div         <= tick ? '0 : div + DIV_W'(1);
      frame_end_d <= tick && (r == 2'd3);

      if (tick) begin
        frame[{r, 2'b00} +: 4] <= ~col_i;
        r <= r + 2'd1;
        if (r == 2'd3) begin
          prev_frame <= full_frame;
          if (full_frame != prev_frame)
            stable_cnt <= 4'd0;
          else if (stable_cnt != 4'(DEBOUNCE))
            stable_cnt <= stable_cnt + 4'd1;
        end
      end

      press_pend <= 1'b0;
      if (frame_end_d && stable_cnt == 4'(DEBOUNCE) && prev_frame != pressed_map) begin
        pressed_map <= prev_frame;
        key_down    <= |prev_frame;
        press_pend  <= |new_bits;
        pend_code   <= lowest;
      end

      // One-entry buffer: an ack on the same edge as a press hands over without a gap.
      if (press_pend) begin
        if (!key_valid) begin
          key_code  <= pend_code;
          key_valid <= 1'b1;
        end else if (key_ack) begin
          key_code  <= pend_code;
          overrun   <= 1'b0;
        end else begin
          overrun   <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
        overrun   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_scan.sv
// tb/tb_key_scan.sv - directed self-checking bench for key_scan
module tb_key_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col_i;
  logic [3:0]  row_o;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        overrun;
  logic        key_down;
  logic [15:0] pressed_map;

  logic [15:0] keys = 16'd0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  key_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rst_n(rst_n), .col_i(col_i), .row_o(row_o),
    .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack),
    .overrun(overrun), .key_down(key_down), .pressed_map(pressed_map)
  );

  always #5 clk = ~clk;

  // Physical keypad: a closed key pulls its column low while its row is driven low.
  always_comb begin
    col_i = 4'b1111;
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        if (!row_o[rr] && keys[rr*4+c]) col_i[c] = 1'b0;
  end

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic do_reset(input logic [15:0] k);
    key_ack = 1'b0;
    keys = k;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    do_reset(16'd0);
    checks++; if (row_o !== 4'b1110) begin errors++; $display("FAIL reset_row got %b exp 1110", row_o); end
    checks++; if ({key_code, key_valid, overrun, key_down} !== 7'd0) begin errors++; $display("FAIL reset_outs got %h/%b/%b/%b exp 0", key_code, key_valid, overrun, key_down); end
    checks++; if (pressed_map !== 16'd0) begin errors++; $display("FAIL reset_map got %h exp 0000", pressed_map); end
    run_to(3);
    checks++; if (row_o !== 4'b1110) begin errors++; $display("FAIL scan_c3 got %b exp 1110", row_o); end
    run_to(4);
    checks++; if (row_o !== 4'b1101) begin errors++; $display("FAIL scan_c4 got %b exp 1101", row_o); end
    run_to(8);
    checks++; if (row_o !== 4'b1011) begin errors++; $display("FAIL scan_c8 got %b exp 1011", row_o); end
    run_to(12);
    checks++; if (row_o !== 4'b0111) begin errors++; $display("FAIL scan_c12 got %b exp 0111", row_o); end
    run_to(16);
    checks++; if (row_o !== 4'b1110) begin errors++; $display("FAIL scan_c16 got %b exp 1110", row_o); end
    run_to(60);
    checks++; if ({key_valid, key_down, pressed_map} !== 18'd0) begin errors++; $display("FAIL idle_quiet got %b/%b/%h exp 0", key_valid, key_down, pressed_map); end
  endtask

  task automatic test_single_press;
    do_reset(16'h0040);
    run_to(49);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", key_valid); end
    checks++; if (pressed_map !== 16'h0040) begin errors++; $display("FAIL single_accept_map got %h exp 0040", pressed_map); end
    run_to(50);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL single_event got v=%b code=%0d exp v=1 code=6", key_valid, key_code); end
    checks++; if (key_down !== 1'b1 || overrun !== 1'b0) begin errors++; $display("FAIL single_flags got down=%b ovr=%b exp 1/0", key_down, overrun); end
    key_ack = 1'b1;
    run_to(51);
    key_ack = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_ack got %b exp 0", key_valid); end
    run_to(130);
    checks++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL single_once got v=%b ovr=%b exp 0/0", key_valid, overrun); end
  endtask

  task automatic test_bounce;
    do_reset(16'h0040);
    run_to(33);
    keys = 16'h0000;
    run_to(48);
    keys = 16'h0040;
    run_to(50);
    checks++; if (key_valid !== 1'b0 || pressed_map !== 16'h0000) begin errors++; $display("FAIL bounce_c50 got v=%b map=%h exp 0/0000", key_valid, pressed_map); end
    run_to(97);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_c97 got %b exp 0", key_valid); end
    run_to(98);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL bounce_event got v=%b code=%0d exp 1/6", key_valid, key_code); end
    key_ack = 1'b1;
    run_to(99);
    key_ack = 1'b0;
    run_to(180);
    checks++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL bounce_once got v=%b ovr=%b exp 0/0", key_valid, overrun); end
  endtask

  task automatic test_simultaneous;
    do_reset(16'h0208);
    run_to(50);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd3) begin errors++; $display("FAIL simul_event got v=%b code=%0d exp 1/3", key_valid, key_code); end
    checks++; if (pressed_map !== 16'h0208 || overrun !== 1'b0) begin errors++; $display("FAIL simul_map got %h ovr=%b exp 0208/0", pressed_map, overrun); end
    keys = 16'h0200;
    key_ack = 1'b1;
    run_to(51);
    key_ack = 1'b0;
    run_to(100);
    checks++; if (pressed_map !== 16'h0200 || key_down !== 1'b1) begin errors++; $display("FAIL simul_release_map got %h down=%b exp 0200/1", pressed_map, key_down); end
    checks++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL simul_no_event got v=%b ovr=%b exp 0/0", key_valid, overrun); end
  endtask

  task automatic test_overrun;
    do_reset(16'h0001);
    run_to(50);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd0) begin errors++; $display("FAIL ovr_first got v=%b code=%0d exp 1/0", key_valid, key_code); end
    keys = 16'h0000;
    run_to(98);
    checks++; if (pressed_map !== 16'h0000 || key_down !== 1'b0) begin errors++; $display("FAIL ovr_release got %h down=%b exp 0000/0", pressed_map, key_down); end
    keys = 16'h0020;
    run_to(145);
    checks++; if (overrun !== 1'b0 || pressed_map !== 16'h0020) begin errors++; $display("FAIL ovr_before got ovr=%b map=%h exp 0/0020", overrun, pressed_map); end
    run_to(146);
    checks++; if (overrun !== 1'b1 || key_code !== 4'd0 || key_valid !== 1'b1) begin errors++; $display("FAIL ovr_set got ovr=%b code=%0d v=%b exp 1/0/1", overrun, key_code, key_valid); end
    key_ack = 1'b1;
    run_to(147);
    key_ack = 1'b0;
    checks++; if (key_valid !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack got v=%b ovr=%b exp 0/0", key_valid, overrun); end
  endtask

  task automatic test_ack_collision;
    do_reset(16'h0001);
    run_to(50);
    keys = 16'h8000;
    run_to(97);
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd0) begin errors++; $display("FAIL coll_pre got v=%b code=%0d exp 1/0", key_valid, key_code); end
    key_ack = 1'b1;
    run_to(98);
    key_ack = 1'b0;
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd15 || overrun !== 1'b0) begin errors++; $display("FAIL coll_load got v=%b code=%0d ovr=%b exp 1/15/0", key_valid, key_code, overrun); end
    checks++; if (pressed_map !== 16'h8000) begin errors++; $display("FAIL coll_map got %h exp 8000", pressed_map); end
  endtask

  task automatic test_reset_mid;
    do_reset(16'h0040);
    run_to(40);
    keys = 16'h0000;
    do_reset(16'h0000);
    run_to(100);
    checks++; if (key_valid !== 1'b0 || pressed_map !== 16'h0000) begin errors++; $display("FAIL midreset got v=%b map=%h exp 0/0000", key_valid, pressed_map); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overrun();
    test_ack_collision();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
